// File: rtl/bus_transfer_sequencer.sv
// Register-transfer issuer for the shared datapath bus.
// Queues {src,dst} requests and plays each out as a DRIVE cycle followed by a LATCH cycle.
module bus_transfer_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [4:0]    req_src,
  input  logic [4:0]    req_dst,
  output logic [31:0]   bus_out_en,
  output logic [31:0]   bus_in_en,
  output logic          xfer_done,
  output logic          xfer_err,
  output logic          busy,
  output logic [AW:0]   fifo_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, LATCH} state_t;

  state_t        state_reg, state_next;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [4:0]    cur_src_reg, cur_src_next;
  logic [4:0]    cur_dst_reg, cur_dst_next;
  logic [9:0]    head;
  logic          push, pop;
  logic          dst_illegal;
  logic [31:0]   src_dec, dst_dec;
  logic [31:0]   out_en_reg, out_en_next;
  logic [31:0]   in_en_reg, in_en_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;

  assign req_ready  = (count_reg != (AW+1)'(DEPTH));
  assign push       = req_valid & req_ready;
  assign head       = mem[rd_ptr_reg];
  assign fifo_count = count_reg;
  assign busy       = (state_reg != IDLE) || (count_reg != '0);

  assign bus_out_en = out_en_reg;
  assign bus_in_en  = in_en_reg;
  assign xfer_done  = done_reg;
  assign xfer_err   = err_reg;

  // Storage is left unreset; the pointers and count alone define what is valid.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr_reg] <= {req_src, req_dst};
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // One-hot decoders driven from the upcoming transfer so the enables can be registered.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_dec
      assign src_dec[gi] = (cur_src_next == 5'(gi));
      assign dst_dec[gi] = (cur_dst_next == 5'(gi));
    end
  endgenerate

  // ZHI, ZLO, InPort and C can drive the bus but never load from it.
  assign dst_illegal = (cur_dst_next == 5'd18) || (cur_dst_next == 5'd19) ||
                       (cur_dst_next == 5'd22) || (cur_dst_next == 5'd23);

  always_comb begin
    state_next   = state_reg;
    cur_src_next = cur_src_reg;
    cur_dst_next = cur_dst_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop          = 1'b1;
          cur_src_next = head[9:5];
          cur_dst_next = head[4:0];
          state_next   = DRIVE;
        end
      end
      DRIVE: state_next = LATCH;
      LATCH: begin
        if (count_reg != '0) begin
          pop          = 1'b1;
          cur_src_next = head[9:5];
          cur_dst_next = head[4:0];
          state_next   = DRIVE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_en_next = '0;
    in_en_next  = '0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    if (state_next == DRIVE) begin
      out_en_next = src_dec;
    end else if (state_next == LATCH) begin
      out_en_next = src_dec;
      in_en_next  = dst_illegal ? '0 : dst_dec;
      done_next   = 1'b1;
      err_next    = dst_illegal;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg   <= IDLE;
      cur_src_reg <= '0;
      cur_dst_reg <= '0;
      out_en_reg  <= '0;
      in_en_reg   <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cur_src_reg <= cur_src_next;
      cur_dst_reg <= cur_dst_next;
      out_en_reg  <= out_en_next;
      in_en_reg   <= in_en_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

endmodule
